alu_sequencer: RTL and testbench

- Control stage that feeds the 8-bit 4-function ALU: accepts 16-bit instructions over a valid/ready handshake and owns a 4-entry x 8-bit register file.
- Drives ALU operands and opcode, captures the ALU result, and writes it back.
- Emits register contents on a result port with its own valid/ready handshake.
- Sits between the instruction source (bench or fetch logic) and the combinational ALU. The ALU is instantiated outside this block.

---
 rtl/alu_pkg.sv | 38 +++
 rtl/alu_sequencer_if.sv | 33 +++
 rtl/seq_regfile.sv | 36 +++
 rtl/alu_sequencer.sv | 126 ++++++++++++
 tb/tb_alu_sequencer.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_pkg : shared encodings for the ALU sequencer                      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package alu_pkg;

  localparam logic [1:0] OP_NAND = 2'b00;
  localparam logic [1:0] OP_NOR  = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_ADD  = 2'b11;

  localparam logic [1:0] KIND_ALU   = 2'b00;
  localparam logic [1:0] KIND_LOADI = 2'b01;
  localparam logic [1:0] KIND_OUT   = 2'b10;
  localparam logic [1:0] KIND_NOP   = 2'b11;

  localparam int KIND_HI = 15;
  localparam int KIND_LO = 14;
  localparam int OPC_HI  = 13;
  localparam int OPC_LO  = 12;
  localparam int RD_HI   = 11;
  localparam int RD_LO   = 10;
  localparam int RS1_HI  = 9;
  localparam int RS1_LO  = 8;
  localparam int RS2_HI  = 7;
  localparam int RS2_LO  = 6;
  localparam int IMM_HI  = 7;
  localparam int IMM_LO  = 0;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EXEC     = 2'd1,
    OUT_WAIT = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_sequencer_if : instruction, ALU and result buses of the sequencer |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface alu_sequencer_if #(
  parameter int DATA_W = 8
);
  logic              instr_valid;
  logic              instr_ready;
  logic [15:0]       instr;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [1:0]        alu_opc;
  logic [DATA_W-1:0] alu_result;
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  logic              zero_flag;
  logic [7:0]        retired;

  // slave is the sequencer; master is the surrounding environment (source, ALU, consumer)
  modport slave (
    input  instr_valid, instr, alu_result, res_ready,
    output instr_ready, alu_a, alu_b, alu_opc, res_valid, res_data, zero_flag, retired
  );

  modport master (
    output instr_valid, instr, alu_result, res_ready,
    input  instr_ready, alu_a, alu_b, alu_opc, res_valid, res_data, zero_flag, retired
  );
endinterface
`default_nettype wire

// File: rtl/seq_regfile.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seq_regfile : NREGS x DATA_W registers, 2 async read ports, 1 write   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module seq_regfile #(
  parameter  int DATA_W = 8,
  parameter  int NREGS  = 4,
  localparam int AW     = $clog2(NREGS)
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              we_i,
  input  wire logic [AW-1:0]     waddr_i,
  input  wire logic [DATA_W-1:0] wdata_i,
  input  wire logic [AW-1:0]     raddr_a_i,
  output logic      [DATA_W-1:0] rdata_a_o,
  input  wire logic [AW-1:0]     raddr_b_i,
  output logic      [DATA_W-1:0] rdata_b_o
);

  logic [DATA_W-1:0] regs_q [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = regs_q[raddr_a_i];
  assign rdata_b_o = regs_q[raddr_b_i];

endmodule
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_sequencer : instruction FSM feeding an external 4-function ALU    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NREGS  = 4
) (
  input wire logic       clk,
  input wire logic       rst_n,
  alu_sequencer_if.slave bus
);

  state_t            state_q;
  logic              ready_en_q;
  logic [1:0]        rd_q;
  logic [DATA_W-1:0] alu_a_q;
  logic [DATA_W-1:0] alu_b_q;
  logic [1:0]        alu_opc_q;
  logic              res_valid_q;
  logic [DATA_W-1:0] res_data_q;
  logic              zero_q;
  logic [7:0]        retired_q;

  logic              we_d;
  logic [1:0]        waddr_d;
  logic [DATA_W-1:0] wdata_d;
  logic [DATA_W-1:0] rf_a;
  logic [DATA_W-1:0] rf_b;
  logic              accept;
  logic [1:0]        kind;

  assign kind   = bus.instr[KIND_HI:KIND_LO];
  // ready_en_q keeps instr_ready low until the first edge after reset release
  assign bus.instr_ready = ready_en_q && (state_q == IDLE);
  assign accept = bus.instr_valid && bus.instr_ready;

  seq_regfile #(.DATA_W(DATA_W), .NREGS(NREGS)) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .we_i      (we_d),
    .waddr_i   (waddr_d),
    .wdata_i   (wdata_d),
    .raddr_a_i (bus.instr[RS1_HI:RS1_LO]),
    .rdata_a_o (rf_a),
    .raddr_b_i (bus.instr[RS2_HI:RS2_LO]),
    .rdata_b_o (rf_b)
  );

  always_comb begin
    we_d    = 1'b0;
    waddr_d = bus.instr[RD_HI:RD_LO];
    wdata_d = DATA_W'(bus.instr[IMM_HI:IMM_LO]);
    if (state_q == EXEC) begin
      we_d    = 1'b1;
      waddr_d = rd_q;
      wdata_d = bus.alu_result;
    end else if (accept && kind == KIND_LOADI) begin
      we_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ready_en_q  <= 1'b0;
      rd_q        <= 2'd0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_opc_q   <= OP_NAND;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      zero_q      <= 1'b0;
      retired_q   <= 8'd0;
    end else begin
      ready_en_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (accept) begin
            case (kind)
              KIND_ALU: begin
                alu_a_q   <= rf_a;
                alu_b_q   <= rf_b;
                alu_opc_q <= bus.instr[OPC_HI:OPC_LO];
                rd_q      <= bus.instr[RD_HI:RD_LO];
                state_q   <= EXEC;
              end
              KIND_OUT: begin
                res_data_q  <= rf_a;
                res_valid_q <= 1'b1;
                state_q     <= OUT_WAIT;
              end
              default: retired_q <= retired_q + 8'd1;  // LOADI and NOP retire on accept
            endcase
          end
        end
        EXEC: begin
          zero_q    <= (bus.alu_result == '0);
          retired_q <= retired_q + 8'd1;
          state_q   <= IDLE;
        end
        OUT_WAIT: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            retired_q   <= retired_q + 8'd1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_opc   = alu_opc_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.zero_flag = zero_q;
  assign bus.retired   = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// Directed-vector bench: stimulus pushes expected OUT values; a monitor checks each result handshake.
module tb_alu_sequencer;
  import alu_pkg::*;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  logic [7:0] exp_q[$];

  alu_sequencer_if #(.DATA_W(8)) bus ();

  alu_sequencer #(.DATA_W(8), .NREGS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // external combinational ALU
  always_comb begin
    case (bus.alu_opc)
      OP_NAND: bus.alu_result = ~(bus.alu_a & bus.alu_b);
      OP_NOR:  bus.alu_result = ~(bus.alu_a | bus.alu_b);
      OP_XOR:  bus.alu_result = bus.alu_a ^ bus.alu_b;
      default: bus.alu_result = bus.alu_a + bus.alu_b;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // result monitor: a handshake completes at the posedge following this sample
  always @(negedge clk) begin
    if (rst_n && bus.res_valid && bus.res_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL res_unexpected: got %0h expected none", bus.res_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (bus.res_data !== e) begin
          n_err++;
          $display("FAIL res_data: got %0h expected %0h", bus.res_data, e);
        end
      end
    end
  end

  function automatic logic [15:0] i_alu(input logic [1:0] opc, rd, rs1, rs2);
    return {KIND_ALU, opc, rd, rs1, rs2, 6'd0};
  endfunction
  function automatic logic [15:0] i_ld(input logic [1:0] rd, input logic [7:0] imm);
    return {KIND_LOADI, 2'b00, rd, 2'b00, imm};
  endfunction
  function automatic logic [15:0] i_out(input logic [1:0] rs);
    return {KIND_OUT, 2'b00, 2'b00, rs, 8'd0};
  endfunction
  localparam logic [15:0] I_NOP = 16'hC000;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // offer one instruction; returns 1 time unit after the accepting edge
  task automatic issue(input logic [15:0] w);
    int waited;
    @(negedge clk);
    bus.instr       = w;
    bus.instr_valid = 1'b1;
    waited = 0;
    while (!bus.instr_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 20) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: got ready=0 expected ready=1 for instr %0h", w);
    end
    tick();
    bus.instr_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr       = 16'd0;
    bus.res_ready   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_retired", bus.retired, 0);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_res_data", bus.res_data, 0);
    check("rst_zero", bus.zero_flag, 0);
    check("rst_ops", {bus.alu_a, bus.alu_b, 6'd0, bus.alu_opc}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("ready_after_rst", bus.instr_ready, 1);

    // ADD wrapping to zero
    bus.res_ready = 1'b1;
    issue(i_ld(2'd0, 8'h0F));
    issue(i_ld(2'd1, 8'hF1));
    issue(i_alu(OP_ADD, 2'd2, 2'd0, 2'd1));
    check("exec_ops", {bus.alu_a, bus.alu_b, 6'd0, bus.alu_opc}, {8'h0F, 8'hF1, 8'h03});
    tick();
    check("add_zero", bus.zero_flag, 1);
    check("add_retired", bus.retired, 3);
    exp_q.push_back(8'h00);
    issue(i_out(2'd2));
    check("out_valid_hi", bus.res_valid, 1);
    tick();
    check("out_valid_1cyc", bus.res_valid, 0);
    check("out_retired", bus.retired, 4);

    // NAND then XOR
    issue(i_ld(2'd0, 8'hFF));
    issue(i_ld(2'd1, 8'hFF));
    issue(i_alu(OP_NAND, 2'd3, 2'd0, 2'd1));
    tick();
    exp_q.push_back(8'h00);
    issue(i_out(2'd3));
    tick();
    issue(i_ld(2'd1, 8'hAA));
    issue(i_alu(OP_XOR, 2'd3, 2'd0, 2'd1));
    tick();
    check("xor_zero", bus.zero_flag, 0);
    exp_q.push_back(8'h55);
    issue(i_out(2'd3));
    tick();
    check("xor_retired", bus.retired, 11);

    // result back-pressure with a held instruction
    issue(i_ld(2'd0, 8'h3C));
    bus.res_ready = 1'b0;
    exp_q.push_back(8'h3C);
    issue(i_out(2'd0));
    bus.instr       = I_NOP;
    bus.instr_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      check("stall_valid", bus.res_valid, 1);
      check("stall_data", bus.res_data, 8'h3C);
      check("stall_ready", bus.instr_ready, 0);
      check("stall_retired", bus.retired, 12);
      tick();
    end
    bus.res_ready = 1'b1;
    tick();
    check("release_valid", bus.res_valid, 0);
    check("release_retired", bus.retired, 13);
    check("release_ready", bus.instr_ready, 1);
    tick();
    bus.instr_valid = 1'b0;
    check("held_nop_accept", bus.retired, 14);

    // back-to-back LOADI
    issue(i_ld(2'd0, 8'h11));
    check("b2b_ret0", bus.retired, 15);
    issue(i_ld(2'd1, 8'h22));
    check("b2b_ret1", bus.retired, 16);
    issue(i_ld(2'd2, 8'h33));
    check("b2b_ret2", bus.retired, 17);
    issue(i_ld(2'd3, 8'h44));
    check("b2b_ret3", bus.retired, 18);
    check("b2b_ready", bus.instr_ready, 1);
    exp_q.push_back(8'h33);
    issue(i_out(2'd2));
    tick();
    exp_q.push_back(8'h22);
    issue(i_out(2'd1));
    tick();

    // reset during EXEC
    issue(i_ld(2'd0, 8'h01));
    issue(i_ld(2'd1, 8'h02));
    issue(i_alu(OP_ADD, 2'd2, 2'd0, 2'd1));
    #1 rst_n = 1'b0;
    #1;
    check("arst_retired", bus.retired, 0);
    check("arst_ops", {bus.alu_a, bus.alu_b, 6'd0, bus.alu_opc}, 0);
    check("arst_zero", bus.zero_flag, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("arst_ready", bus.instr_ready, 1);
    exp_q.push_back(8'h00);
    issue(i_out(2'd2));
    tick();
    exp_q.push_back(8'h00);
    issue(i_out(2'd0));
    tick();

    // reset during OUT_WAIT
    bus.res_ready = 1'b0;
    issue(i_ld(2'd0, 8'h5A));
    issue(i_out(2'd0));
    check("ow_valid", bus.res_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("ow_arst_valid", bus.res_valid, 0);
    check("ow_arst_data", bus.res_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    bus.res_ready = 1'b1;

    // retired wrap with 256 NOPs
    issue(i_alu(OP_ADD, 2'd2, 2'd0, 2'd0));
    tick();
    check("wrap_zero_set", bus.zero_flag, 1);
    issue(i_ld(2'd3, 8'h77));
    check("wrap_pre", bus.retired, 2);
    for (int k = 0; k < 254; k++) issue(I_NOP);
    check("wrap_zero_cnt", bus.retired, 0);
    issue(I_NOP);
    issue(I_NOP);
    check("wrap_post", bus.retired, 2);
    check("wrap_zero_kept", bus.zero_flag, 1);
    exp_q.push_back(8'h77);
    issue(i_out(2'd3));
    tick();
    tick();

    check("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
